// File: rtl/wb_pkg.sv
// Shared types for the writeback block: load funct3 codes, queue entry and load-data alignment.
package wb_pkg;

    localparam int unsigned LQ_DEPTH_DEFAULT = 4;

    typedef enum logic [2:0] {
        F3_LB  = 3'b000,
        F3_LH  = 3'b001,
        F3_LW  = 3'b010,
        F3_LBU = 3'b100,
        F3_LHU = 3'b101
    } load_f3_e;

    typedef struct packed {
        logic [4:0] rd;
        logic [2:0] funct3;
        logic [1:0] off;
    } lq_entry_t;

    // Unlisted funct3 codes fall through to a full-word load.
    function automatic logic [31:0] load_extend(input logic [2:0]  funct3,
                                                input logic [1:0]  off,
                                                input logic [31:0] rdata);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = rdata[{off, 3'b000} +: 8];
        h = off[1] ? rdata[31:16] : rdata[15:0];
        case (funct3)
            F3_LB:   r = {{24{b[7]}}, b};
            F3_LH:   r = {{16{h[15]}}, h};
            F3_LBU:  r = {24'h0, b};
            F3_LHU:  r = {16'h0, h};
            default: r = rdata;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/reg_writeback_if.sv
// Request/response and register-file write signals of the writeback stage.
interface reg_writeback_if;

    logic        alu_valid;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        alu_ready;

    logic        ld_req_valid;
    logic [4:0]  ld_req_rd;
    logic [2:0]  ld_req_funct3;
    logic [1:0]  ld_req_off;
    logic        ld_req_ready;

    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    logic [4:0]  dec_rs1;
    logic [4:0]  dec_rs2;
    logic [4:0]  dec_rd;
    logic        stall;

    logic        reg_write;
    logic [4:0]  wb_rd_addr;
    logic [31:0] back_rd_data;
    logic [31:0] busy;
    logic        err_unexp;

    modport slave (
        input  alu_valid, alu_rd, alu_data,
        output alu_ready,
        input  ld_req_valid, ld_req_rd, ld_req_funct3, ld_req_off,
        output ld_req_ready,
        input  mem_rvalid, mem_rdata,
        input  dec_rs1, dec_rs2, dec_rd,
        output stall,
        output reg_write, wb_rd_addr, back_rd_data, busy, err_unexp
    );

    modport master (
        output alu_valid, alu_rd, alu_data,
        input  alu_ready,
        output ld_req_valid, ld_req_rd, ld_req_funct3, ld_req_off,
        input  ld_req_ready,
        output mem_rvalid, mem_rdata,
        output dec_rs1, dec_rs2, dec_rd,
        input  stall,
        input  reg_write, wb_rd_addr, back_rd_data, busy, err_unexp
    );

endinterface

// File: rtl/load_queue.sv
// In-order FIFO of outstanding loads; head entry describes the next memory response.
module load_queue
    import wb_pkg::*;
#(
    parameter int unsigned DEPTH = LQ_DEPTH_DEFAULT,
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  lq_entry_t        push_entry,
    input  logic             pop,
    output lq_entry_t        head,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    lq_entry_t        mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= next_ptr(wr_ptr);
            if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_entry;
    end

endmodule

// File: rtl/reg_writeback.sv
// Register writeback stage: arbitrates load returns over ALU results and tracks pending-load scoreboard.
module reg_writeback
    import wb_pkg::*;
#(
    parameter int unsigned LQ_DEPTH = LQ_DEPTH_DEFAULT
) (
    input logic           clk,
    input logic           rst,
    reg_writeback_if.slave wb
);

    localparam int unsigned CNT_W = $clog2(LQ_DEPTH + 1);

    lq_entry_t        push_entry;
    lq_entry_t        head;
    logic             full;
    logic             empty;
    logic [CNT_W-1:0] count;
    logic             push;
    logic             pop;
    logic             alu_fire;

    logic [31:0]      busy_q;
    logic             clr_valid;
    logic [4:0]       clr_rd;
    logic             reg_write_q;
    logic [4:0]       wb_rd_q;
    logic [31:0]      wb_data_q;
    logic             err_q;

    assign push_entry = '{rd: wb.ld_req_rd, funct3: wb.ld_req_funct3, off: wb.ld_req_off};

    // Same-rd loads are held off until the earlier one retires (WAW).
    assign wb.ld_req_ready = !full && !busy_q[wb.ld_req_rd];
    assign wb.alu_ready    = !(wb.mem_rvalid && count != '0);
    assign wb.stall        = busy_q[wb.dec_rs1] | busy_q[wb.dec_rs2] | busy_q[wb.dec_rd];
    assign wb.busy         = busy_q;
    assign wb.reg_write    = reg_write_q;
    assign wb.wb_rd_addr   = wb_rd_q;
    assign wb.back_rd_data = wb_data_q;
    assign wb.err_unexp    = err_q;

    assign push     = wb.ld_req_valid && wb.ld_req_ready;
    assign pop      = wb.mem_rvalid && !empty;
    assign alu_fire = wb.alu_valid && wb.alu_ready;

    load_queue #(.DEPTH(LQ_DEPTH)) u_lq (
        .clk        (clk),
        .rst        (rst),
        .push       (push),
        .push_entry (push_entry),
        .pop        (pop),
        .head       (head),
        .full       (full),
        .empty      (empty),
        .count      (count)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            reg_write_q <= 1'b0;
            wb_rd_q     <= '0;
            wb_data_q   <= '0;
        end else if (pop) begin
            reg_write_q <= (head.rd != '0);
            wb_rd_q     <= head.rd;
            wb_data_q   <= load_extend(head.funct3, head.off, wb.mem_rdata);
        end else if (alu_fire) begin
            reg_write_q <= (wb.alu_rd != '0);
            wb_rd_q     <= wb.alu_rd;
            wb_data_q   <= wb.alu_data;
        end else begin
            reg_write_q <= 1'b0;
        end
    end

    // Busy clears one edge after the pop, i.e. when the register file takes the write.
    // A push can never target clr_rd: that register is still busy so ld_req_ready is low.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q    <= '0;
            clr_valid <= 1'b0;
            clr_rd    <= '0;
            err_q     <= 1'b0;
        end else begin
            clr_valid <= pop;
            clr_rd    <= head.rd;
            if (clr_valid) busy_q[clr_rd] <= 1'b0;
            if (push && wb.ld_req_rd != '0) busy_q[wb.ld_req_rd] <= 1'b1;
            if (wb.mem_rvalid && empty) err_q <= 1'b1;
        end
    end

endmodule

// File: tb/tb_reg_writeback.sv
// Directed self-checking bench for reg_writeback with hand-computed expectations.
module tb_reg_writeback;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    reg_writeback_if bus ();

    reg_writeback #(.LQ_DEPTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .wb  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [4:0]  t_rd    [8] = '{5'd4, 5'd4, 5'd6, 5'd8, 5'd10, 5'd11, 5'd0, 5'd12};
    logic [2:0]  t_f3    [8] = '{3'b001, 3'b001, 3'b100, 3'b010, 3'b111, 3'b101, 3'b000, 3'b000};
    logic [1:0]  t_off   [8] = '{2'd0, 2'd2, 2'd3, 2'd1, 2'd0, 2'd0, 2'd0, 2'd1};
    logic [31:0] t_rdata [8] = '{32'h00008001, 32'h7FFF0000, 32'h9A000000, 32'hDEADBEEF,
                                 32'h12345678, 32'h0000F00F, 32'h000000FF, 32'h00007F00};
    logic [31:0] t_exp   [8] = '{32'hFFFF8001, 32'h00007FFF, 32'h0000009A, 32'hDEADBEEF,
                                 32'h12345678, 32'h0000F00F, 32'h000000FF, 32'h0000007F};
    logic        t_we    [8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b0;
        bus.alu_valid = 1'b0;      bus.alu_rd = '0;         bus.alu_data = '0;
        bus.ld_req_valid = 1'b0;   bus.ld_req_rd = '0;      bus.ld_req_funct3 = '0;
        bus.ld_req_off = '0;       bus.mem_rvalid = 1'b0;   bus.mem_rdata = '0;
        bus.dec_rs1 = '0;          bus.dec_rs2 = '0;        bus.dec_rd = '0;
        #2 rst = 1'b1;
        tick;
        tick;

        chk("rst_reg_write", 32'(bus.reg_write), 32'd0);
        chk("rst_wb_addr", 32'(bus.wb_rd_addr), 32'd0);
        chk("rst_wb_data", bus.back_rd_data, 32'd0);
        chk("rst_busy", bus.busy, 32'd0);
        chk("rst_err", 32'(bus.err_unexp), 32'd0);
        chk("rst_ld_ready", 32'(bus.ld_req_ready), 32'd1);
        chk("rst_alu_ready", 32'(bus.alu_ready), 32'd1);
        chk("rst_stall", 32'(bus.stall), 32'd0);
        rst = 1'b0;
        tick;

        // ALU write rd=5
        bus.alu_valid = 1'b1; bus.alu_rd = 5'd5; bus.alu_data = 32'h1234;
        chk("alu_ready_idle", 32'(bus.alu_ready), 32'd1);
        tick;
        bus.alu_valid = 1'b0;
        chk("alu_we", 32'(bus.reg_write), 32'd1);
        chk("alu_addr", 32'(bus.wb_rd_addr), 32'd5);
        chk("alu_data", bus.back_rd_data, 32'h1234);
        tick;
        chk("alu_we_drop", 32'(bus.reg_write), 32'd0);

        // ALU write to x0 is suppressed
        bus.alu_valid = 1'b1; bus.alu_rd = 5'd0; bus.alu_data = 32'h5;
        tick;
        bus.alu_valid = 1'b0;
        chk("alu_x0_we", 32'(bus.reg_write), 32'd0);

        // LB rd=7 off=2, plus busy / stall / WAW
        bus.ld_req_valid = 1'b1; bus.ld_req_rd = 5'd7; bus.ld_req_funct3 = 3'b000; bus.ld_req_off = 2'd2;
        chk("lb_ready", 32'(bus.ld_req_ready), 32'd1);
        tick;
        bus.ld_req_valid = 1'b0;
        chk("lb_busy_set", bus.busy, 32'h00000080);
        chk("lb_no_write", 32'(bus.reg_write), 32'd0);
        bus.dec_rs1 = 5'd7;
        #1 chk("stall_rs1", 32'(bus.stall), 32'd1);
        bus.dec_rs1 = 5'd0; bus.dec_rd = 5'd7;
        #1 chk("stall_rd", 32'(bus.stall), 32'd1);
        bus.dec_rd = 5'd0; bus.dec_rs2 = 5'd6;
        #1 chk("stall_clear", 32'(bus.stall), 32'd0);
        bus.dec_rs2 = 5'd0;
        bus.ld_req_valid = 1'b1; bus.ld_req_rd = 5'd7;
        #1 chk("waw_ready", 32'(bus.ld_req_ready), 32'd0);
        bus.ld_req_valid = 1'b0;
        bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h00800000;
        #1 chk("lb_alu_ready", 32'(bus.alu_ready), 32'd0);
        tick;
        bus.mem_rvalid = 1'b0;
        chk("lb_we", 32'(bus.reg_write), 32'd1);
        chk("lb_addr", 32'(bus.wb_rd_addr), 32'd7);
        chk("lb_data", bus.back_rd_data, 32'hFFFFFF80);
        chk("lb_busy_wb", bus.busy, 32'h00000080);
        tick;
        chk("lb_busy_clr", bus.busy, 32'd0);
        chk("lb_we_drop", 32'(bus.reg_write), 32'd0);

        // load return and ALU in the same cycle
        bus.ld_req_valid = 1'b1; bus.ld_req_rd = 5'd3; bus.ld_req_funct3 = 3'b101; bus.ld_req_off = 2'd2;
        tick;
        bus.ld_req_valid = 1'b0;
        bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'hABCD1234;
        bus.alu_valid = 1'b1; bus.alu_rd = 5'd9; bus.alu_data = 32'hCAFE;
        #1 chk("pri_alu_ready", 32'(bus.alu_ready), 32'd0);
        tick;
        bus.mem_rvalid = 1'b0;
        #1 chk("pri_alu_ready2", 32'(bus.alu_ready), 32'd1);
        chk("pri_ld_addr", 32'(bus.wb_rd_addr), 32'd3);
        chk("pri_ld_data", bus.back_rd_data, 32'h0000ABCD);
        tick;
        bus.alu_valid = 1'b0;
        chk("pri_alu_we", 32'(bus.reg_write), 32'd1);
        chk("pri_alu_addr", 32'(bus.wb_rd_addr), 32'd9);
        chk("pri_alu_data", bus.back_rd_data, 32'h0000CAFE);
        tick;

        // load format table
        for (int i = 0; i < 8; i++) begin
            bus.ld_req_valid = 1'b1; bus.ld_req_rd = t_rd[i];
            bus.ld_req_funct3 = t_f3[i]; bus.ld_req_off = t_off[i];
            tick;
            bus.ld_req_valid = 1'b0;
            bus.mem_rvalid = 1'b1; bus.mem_rdata = t_rdata[i];
            tick;
            bus.mem_rvalid = 1'b0;
            chk($sformatf("tbl%0d_we", i), 32'(bus.reg_write), 32'(t_we[i]));
            if (t_we[i]) begin
                chk($sformatf("tbl%0d_addr", i), 32'(bus.wb_rd_addr), 32'(t_rd[i]));
                chk($sformatf("tbl%0d_data", i), bus.back_rd_data, t_exp[i]);
            end
            tick;
        end
        chk("tbl_busy_clear", bus.busy, 32'd0);

        // fill queue, then simultaneous push and pop
        for (int r = 13; r <= 16; r++) begin
            bus.ld_req_valid = 1'b1; bus.ld_req_rd = 5'(r);
            bus.ld_req_funct3 = 3'b010; bus.ld_req_off = 2'd0;
            #1 chk($sformatf("fill%0d_ready", r), 32'(bus.ld_req_ready), 32'd1);
            tick;
        end
        bus.ld_req_rd = 5'd17;
        #1 chk("full_ready", 32'(bus.ld_req_ready), 32'd0);
        bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h0;
        tick;
        bus.mem_rvalid = 1'b0;
        #1 chk("after_pop_ready", 32'(bus.ld_req_ready), 32'd1);
        bus.mem_rvalid = 1'b1;
        tick;
        bus.mem_rvalid = 1'b0;
        bus.ld_req_rd = 5'd18;
        #1 chk("pp_wb_addr", 32'(bus.wb_rd_addr), 32'd14);
        chk("pp_ready", 32'(bus.ld_req_ready), 32'd1);
        tick;
        bus.ld_req_rd = 5'd19;
        #1 chk("refill_ready", 32'(bus.ld_req_ready), 32'd0);
        chk("refill_busy", bus.busy, 32'h00078000);
        bus.ld_req_valid = 1'b0;

        // reset mid-queue, then unexpected response
        rst = 1'b1;
        #1 chk("mid_rst_busy", bus.busy, 32'd0);
        chk("mid_rst_we", 32'(bus.reg_write), 32'd0);
        chk("mid_rst_data", bus.back_rd_data, 32'd0);
        bus.ld_req_valid = 1'b1; bus.ld_req_rd = 5'd19;
        #1 chk("mid_rst_ready", 32'(bus.ld_req_ready), 32'd1);
        bus.ld_req_valid = 1'b0;
        tick;
        rst = 1'b0;
        bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h55;
        #1 chk("unexp_alu_ready", 32'(bus.alu_ready), 32'd1);
        tick;
        bus.mem_rvalid = 1'b0;
        chk("unexp_we", 32'(bus.reg_write), 32'd0);
        chk("unexp_err", 32'(bus.err_unexp), 32'd1);
        tick;
        chk("unexp_err_sticky", 32'(bus.err_unexp), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
